// File: rtl/ow_p2s_shifter.sv
// Parallel-to-serial shifter for the 1-Wire master write path: valid/ready frame load, one bit
// per slot-timer request, abort. Define OW_P2S_CRC_EN to add a Dallas CRC-8 of the emitted bits.
module ow_p2s_shifter #(
  parameter int unsigned WIDTH     = 64,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    load_len,
  input  logic             bit_req,
  input  logic             abort,
  output logic             bit_value,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             done,
  output logic [7:0]       crc_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [CW-1:0] WidthCw = CW'(WIDTH);
  localparam logic [CW-1:0] OneCw   = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic             bit_value_q, bit_value_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             done_q, done_d;

  logic [CW-1:0]    eff_len;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             emit;

  // Zero or oversize length means a full-width frame.
  assign eff_len = ((load_len == '0) || (load_len > WidthCw)) ? WidthCw : load_len;
  assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  // done_q keeps load_ready low for the done cycle even though the state is already idle.
  assign load_ready = (state_q == StIdle) && !done_q;
  assign accept     = (state_q == StIdle) && load_valid && load_ready && !abort;
  assign emit       = (state_q == StShift) && bit_req && !abort;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    remaining_d = remaining_q;
    bit_value_d = bit_value_q;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = StIdle;
      bit_value_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_d     = load_data;
            remaining_d = eff_len;
            state_d     = StShift;
          end
        end
        StShift: begin
          if (emit) begin
            bit_value_d = out_bit;
            shreg_d     = shifted;
            remaining_d = remaining_q - OneCw;
            bit_valid_d = 1'b1;
            if (remaining_q == OneCw) begin
              last_bit_d = 1'b1;
              state_d    = StDone;
            end
          end
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      remaining_q <= '0;
      bit_value_q <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      remaining_q <= remaining_d;
      bit_value_q <= bit_value_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
      done_q      <= done_d;
    end
  end

  assign bit_value = bit_value_q;
  assign bit_valid = bit_valid_q;
  assign last_bit  = last_bit_q;
  assign done      = done_q;

`ifdef OW_P2S_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_fb;

  assign crc_fb = crc_q[0] ^ out_bit;

  always_comb begin
    crc_d = crc_q;
    if (abort || accept) begin
      crc_d = 8'h00;
    end else if (emit) begin
      crc_d = (crc_q >> 1) ^ (crc_fb ? 8'h8C : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 8'h00;
`endif

endmodule

// File: tb/tb_ow_p2s_shifter.sv
// Directed bench for ow_p2s_shifter: a 64-bit LSB-first instance and an 8-bit MSB-first instance.
module tb_ow_p2s_shifter;

  localparam int unsigned WA  = 64;
  localparam int unsigned CWA = $clog2(WA + 1);
  localparam int unsigned WB  = 8;
  localparam int unsigned CWB = $clog2(WB + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           a_load_valid, a_load_ready, a_bit_req, a_abort;
  logic [WA-1:0]  a_load_data;
  logic [CWA-1:0] a_load_len;
  logic           a_bit_value, a_bit_valid, a_last_bit, a_done;
  logic [7:0]     a_crc;

  logic           b_load_valid, b_load_ready, b_bit_req, b_abort;
  logic [WB-1:0]  b_load_data;
  logic [CWB-1:0] b_load_len;
  logic           b_bit_value, b_bit_valid, b_last_bit, b_done;
  logic [7:0]     b_crc;

  ow_p2s_shifter #(.WIDTH(WA), .MSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst(rst),
    .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_data(a_load_data), .load_len(a_load_len),
    .bit_req(a_bit_req), .abort(a_abort),
    .bit_value(a_bit_value), .bit_valid(a_bit_valid),
    .last_bit(a_last_bit), .done(a_done), .crc_out(a_crc)
  );

  ow_p2s_shifter #(.WIDTH(WB), .MSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst),
    .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_data(b_load_data), .load_len(b_load_len),
    .bit_req(b_bit_req), .abort(b_abort),
    .bit_value(b_bit_value), .bit_valid(b_bit_valid),
    .last_bit(b_last_bit), .done(b_done), .crc_out(b_crc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [WA-1:0] d, input logic [CWA-1:0] len);
    check("a_ready_before_load", a_load_ready, 1);
    a_load_data  = d;
    a_load_len   = len;
    a_load_valid = 1'b1;
    tick;
    a_load_valid = 1'b0;
    check("a_ready_in_shift", a_load_ready, 0);
  endtask

  // Requests a bit every cycle until last_bit shows up or the budget runs out.
  task automatic run_a(input int max_bits, output int cnt);
    cnt = 0;
    a_bit_req = 1'b1;
    for (int i = 0; i < max_bits + 2; i++) begin
      tick;
      if (a_bit_valid) cnt++;
      if (a_last_bit) break;
    end
    a_bit_req = 1'b0;
  endtask

  logic [7:0] exp_a5 = 8'hA5;
  logic [7:0] exp_c3 = 8'hC3;
  logic [7:0] exp_crc56;
  int         cnt;

  initial begin
`ifdef OW_P2S_CRC_EN
    exp_crc56 = 8'hA2;
`else
    exp_crc56 = 8'h00;
`endif
    rst = 1'b1;
    a_load_valid = 0; a_load_data = '0; a_load_len = '0; a_bit_req = 0; a_abort = 0;
    b_load_valid = 0; b_load_data = '0; b_load_len = '0; b_bit_req = 0; b_abort = 0;
    repeat (3) tick;
    check("rst_ready", a_load_ready, 1);
    check("rst_value", a_bit_value, 0);
    check("rst_valid", a_bit_valid, 0);
    check("rst_last", a_last_bit, 0);
    check("rst_done", a_done, 0);
    check("rst_crc", a_crc, 0);
    check("rst_b_ready", b_load_ready, 1);
    rst = 1'b0;
    tick;

    // Requests while idle are ignored.
    a_bit_req = 1'b1;
    tick;
    tick;
    check("idle_req_valid", a_bit_valid, 0);
    check("idle_req_ready", a_load_ready, 1);
    a_bit_req = 1'b0;
    tick;

    // Byte frame, LSB-first, request every 4 cycles.
    load_a(64'hA5, 7'd8);
    for (int i = 0; i < 8; i++) begin
      repeat (3) tick;
      a_bit_req = 1'b1;
      tick;
      a_bit_req = 1'b0;
      check("a5_valid", a_bit_valid, 1);
      check("a5_value", a_bit_value, exp_a5[i]);
      check("a5_last", a_last_bit, (i == 7) ? 1 : 0);
      check("a5_done_early", a_done, 0);
    end
    tick;
    check("a5_done", a_done, 1);
    check("a5_done_ready", a_load_ready, 0);
    check("a5_done_valid", a_bit_valid, 0);
    check("a5_hold_value", a_bit_value, 1);
    tick;
    check("a5_done_clear", a_done, 0);
    check("a5_ready_again", a_load_ready, 1);

    // MSB-first 8-bit instance, len 0 means full width, back-to-back requests.
    check("b_ready_before", b_load_ready, 1);
    b_load_data  = 8'hC3;
    b_load_len   = '0;
    b_load_valid = 1'b1;
    tick;
    b_load_valid = 1'b0;
    b_bit_req    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      check("c3_valid", b_bit_valid, 1);
      check("c3_value", b_bit_value, exp_c3[7-i]);
      check("c3_last", b_last_bit, (i == 7) ? 1 : 0);
    end
    b_bit_req = 1'b0;
    tick;
    check("c3_done", b_done, 1);
    tick;

    // ROM-ID CRC: 56 bits give the CRC byte, 64 bits (with CRC byte) give zero.
    load_a(64'hA2000000_01B81C02, 7'd56);
    run_a(56, cnt);
    check("crc56_count", cnt, 56);
    tick;
    check("crc56_done", a_done, 1);
    check("crc56_value", a_crc, exp_crc56);
    tick;
    load_a(64'hA2000000_01B81C02, 7'd64);
    run_a(64, cnt);
    check("crc64_count", cnt, 64);
    tick;
    check("crc64_done", a_done, 1);
    check("crc64_value", a_crc, 0);
    tick;

    // Oversize length clamps to WIDTH.
    load_a({WA{1'b1}}, 7'd69);
    run_a(70, cnt);
    check("len69_count", cnt, 64);
    tick;
    check("len69_done", a_done, 1);
    tick;

    // len=1 with load_valid held through the frame.
    a_load_data  = 64'h1;
    a_load_len   = 7'd1;
    a_load_valid = 1'b1;
    tick;
    a_load_data  = 64'h0;
    check("hold_ready_shift", a_load_ready, 0);
    tick;
    check("hold_ready_shift2", a_load_ready, 0);
    check("hold_no_valid", a_bit_valid, 0);
    a_bit_req = 1'b1;
    tick;
    a_bit_req = 1'b0;
    check("len1_valid", a_bit_valid, 1);
    check("len1_last", a_last_bit, 1);
    check("len1_value", a_bit_value, 1);
    tick;
    check("len1_done", a_done, 1);
    check("len1_done_ready", a_load_ready, 0);
    tick;
    check("len1_ready", a_load_ready, 1);
    tick;
    a_load_valid = 1'b0;
    check("second_accepted", a_load_ready, 0);
    a_bit_req = 1'b1;
    tick;
    a_bit_req = 1'b0;
    check("second_value", a_bit_value, 0);
    check("second_last", a_last_bit, 1);
    tick;
    tick;

    // Abort on the 5th request.
    load_a(64'hFFFF, 7'd16);
    a_bit_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("abort_pre_value", a_bit_value, 1);
    end
    a_abort = 1'b1;
    tick;
    a_abort   = 1'b0;
    a_bit_req = 1'b0;
    check("abort_valid", a_bit_valid, 0);
    check("abort_value", a_bit_value, 0);
    check("abort_done", a_done, 0);
    check("abort_ready", a_load_ready, 1);
    check("abort_crc", a_crc, 0);
    tick;
    check("abort_no_done", a_done, 0);
    load_a(64'hA5, 7'd8);
    run_a(8, cnt);
    check("post_abort_count", cnt, 8);
    tick;
    check("post_abort_done", a_done, 1);
    tick;

    // Asynchronous reset mid-frame.
    load_a(64'hFFFF, 7'd16);
    a_bit_req = 1'b1;
    tick;
    tick;
    a_bit_req = 1'b0;
    check("pre_rst_value", a_bit_value, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ready", a_load_ready, 1);
    check("async_rst_value", a_bit_value, 0);
    check("async_rst_valid", a_bit_valid, 0);
    #1;
    rst = 1'b0;
    tick;
    check("post_rst_done", a_done, 0);
    check("post_rst_ready", a_load_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ow_p2s_shifter.md
# ow_p2s_shifter

Parameterised parallel-to-serial shifter for the 1-Wire master datapath. It accepts a word of up to WIDTH bits through a valid/ready load handshake, then emits one bit per request from the slot timer. Frame length and bit order are configurable, and an abort input discards the frame. It sits between the command/ROM register file and the 1-Wire write-slot generator, and replaces the free-running converter used for fixed 8-bit frames.

## Interface
- WIDTH, 64, maximum frame length in bits (≥2); 64 covers a full ROM ID
- MSB_FIRST, 0, 0 = LSB-first (1-Wire native); 1 = MSB-first
- CW, $clog2(WIDTH+1), width of the length field (derived; do not override)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_valid  in  1  frame offered
- load_ready  out  1  block can accept a frame
- load_data  in  WIDTH  frame bits; bit 0 is the first bit sent when LSB-first
- load_len  in  CW  number of bits to send; 0 or >WIDTH means WIDTH
- bit_req  in  1  single-cycle request for the next bit (from the slot timer)
- abort  in  1  synchronous frame cancel
- bit_value  out  1  current serial bit, held between updates
- bit_valid  out  1  one-cycle pulse: bit_value has just been updated
- last_bit  out  1  high together with bit_valid for the final bit of the frame
- done  out  1  one-cycle pulse after the final bit of the frame
- crc_out  out  8  Dallas CRC-8 of the bits sent (only with the macro; 0 otherwise)

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: capture load_data into the shift register, set remaining = effective length, clear the CRC, go to SHIFT.
  - bit_req is ignored.
- SHIFT:
  - load_ready=0; load_valid is ignored.
  - On bit_req: bit_value ← shreg[0] (LSB-first) or shreg[WIDTH-1] (MSB-first).
  - Shift the register toward the emitted end, fill with 0, decrement remaining, pulse bit_valid.
  - If remaining was 1: also assert last_bit and go to DONE.
- DONE:
  - done=1 for exactly one cycle, load_ready=0, then go to IDLE.
  - bit_req is ignored.
- abort:
  - In any state, go to IDLE on the next edge.
  - Clears bit_value, bit_valid, last_bit and done.
  - Takes priority over bit_req and load in the same cycle; no done pulse.
- Remaining counter: CW bits. It never wraps, because it only decrements in SHIFT while it is ≥1.
- bit_value holds its last value after DONE until the next emitted bit, abort or reset.

## Timing
- Reset values:
  - load_ready=1 (IDLE).
  - bit_value, bit_valid, last_bit, done all 0.
  - crc_out=0.
  - Shift register and counter 0.
- Load latency: handshake at edge n puts the block in SHIFT at n; the first bit_req is honoured from cycle n+1.
- bit_req sampled at edge k gives bit_value/bit_valid registered at edge k; they are visible in cycle k+1.
- Back-to-back bit_req every cycle is legal: one bit per cycle.
- Final bit at edge k, done at edge k+1, load_ready=1 again from edge k+2.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous); no done pulse.

## Configuration
- OW_P2S_CRC_EN defined:
  - An 8-bit CRC register updates on every emitted bit: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 8'h8C : 0).
  - The register is cleared on load accept and on abort; crc_out is driven from it.
  - crc_out is final in the cycle done=1.
- OW_P2S_CRC_EN undefined: no CRC logic; crc_out is tied to 8'h00. The port list is identical in both builds.

## Test plan
- Reset then idle: assert rst for 3 cycles -> load_ready=1, all other outputs 0; bit_req pulses produce no bit_valid.
- Byte frame, LSB-first, WIDTH=64: load 64'h00…A5 with len=8, bit_req every 4 cycles -> bits 1,0,1,0,0,1,0,1; last_bit on the 8th; done 1 cycle later; load_ready the cycle after.
- MSB_FIRST=1, WIDTH=8: load 8'hC3 with len=0, back-to-back bit_req -> bits 1,1,0,0,0,0,1,1 on 8 consecutive cycles, then done.
- CRC (macro on): load 64'hA2000000_01B81C02 with len=56 -> crc_out=8'hA2 at done. The same word with len=64 -> crc_out=8'h00.
- Abort: load 16'hFFFF with len=16, abort on the same cycle as the 5th bit_req -> no bit_valid for that request, bit_value=0, no done; load_ready=1 next cycle and a new load is accepted.
- Edge cases:
  - len=1 -> single bit_valid with last_bit=1.
  - len=WIDTH+5 -> exactly WIDTH bits.
  - load_valid held during SHIFT -> not accepted until IDLE.
